// File: rtl/ecc_pkg.sv
// Shared types and SEC-DED helpers for the ECC memory controller.
// Scrubber build option: ECC_SCRUB_EN.
package ecc_pkg;

    localparam int DATA_W = 32;
    localparam int CODE_W = 39;

    localparam int P1_IDX  = 32;
    localparam int P2_IDX  = 33;
    localparam int P4_IDX  = 34;
    localparam int P8_IDX  = 35;
    localparam int P16_IDX = 36;
    localparam int P32_IDX = 37;
    localparam int PG_IDX  = 38;

    typedef enum logic [3:0] {
        IDLE, WR, RD, CHK, WB, RESP, S_RD, S_CHK, S_WB
    } state_t;

    typedef struct packed {
        logic              pg;
        logic [5:0]        p;
        logic [DATA_W-1:0] d;
    } cw_t;

    // Hamming position (3..38, powers of two skipped) of data bit idx
    function automatic logic [5:0] data_pos(input int idx);
        int         cnt;
        logic [5:0] pos;
        cnt = 0;
        pos = 6'd0;
        for (int h = 3; h <= 38; h++) begin
            if ((h & (h - 1)) != 0) begin
                if (cnt == idx) pos = 6'(h);
                cnt++;
            end
        end
        return pos;
    endfunction

    // Six Hamming check bits over the data word
    function automatic logic [5:0] ham_par(input logic [DATA_W-1:0] d);
        logic [5:0] p;
        logic [5:0] pos;
        p = 6'd0;
        for (int i = 0; i < DATA_W; i++) begin
            pos = data_pos(i);
            for (int k = 0; k < 6; k++) begin
                if (pos[k]) p[k] = p[k] ^ d[i];
            end
        end
        return p;
    endfunction

    // Data-bit flip mask selected by a syndrome
    function automatic logic [DATA_W-1:0] syn_mask(input logic [5:0] s);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (data_pos(i) == s) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ecc_codec.sv
// Combinational SEC-DED encoder and decoder for 39-bit codewords.
// Scrubber build option: ECC_SCRUB_EN (not used here).
module ecc_codec
    import ecc_pkg::*;
(
    input  logic [DATA_W-1:0] i_enc_data,
    output logic [CODE_W-1:0] o_enc_code,
    input  logic [CODE_W-1:0] i_dec_code,
    output logic [DATA_W-1:0] o_dec_data,
    output logic              o_dec_corr,
    output logic              o_dec_uncorr
);

    logic [5:0] w_ep;
    logic [5:0] w_syn;
    logic       w_odd;
    cw_t        w_enc;

    assign w_ep      = ham_par(i_enc_data);
    assign w_enc.d   = i_enc_data;
    assign w_enc.p   = w_ep;
    assign w_enc.pg  = ^{w_ep, i_enc_data};
    assign o_enc_code = w_enc;

    assign w_syn = ham_par(i_dec_code[DATA_W-1:0]) ^ i_dec_code[P32_IDX:P1_IDX];
    assign w_odd = ^i_dec_code;

    // Classify the error and repair a single flipped data bit
    always_comb begin
        o_dec_data   = i_dec_code[DATA_W-1:0];
        o_dec_corr   = 1'b0;
        o_dec_uncorr = 1'b0;
        if (w_syn == 6'd0) begin
            o_dec_corr = w_odd;
        end else if (!w_odd || (w_syn > 6'd38)) begin
            o_dec_uncorr = 1'b1;
        end else begin
            o_dec_corr = 1'b1;
            o_dec_data = i_dec_code[DATA_W-1:0] ^ syn_mask(w_syn);
        end
    end

endmodule

// File: rtl/ecc_mem_ctrl.sv
// SEC-DED word memory controller with RMW stores and error counters.
// Define ECC_SCRUB_EN to build in the background scrubber.
module ecc_mem_ctrl
    import ecc_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int AW             = $clog2(DEPTH),
    parameter int SCRUB_INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [3:0]        req_be,
    input  logic [AW-1:0]     req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_corr,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [CODE_W-1:0] mem_wdata,
    input  logic [CODE_W-1:0] mem_rdata,
    output logic [15:0]       ce_count,
    output logic [15:0]       ue_count,
    output logic [AW-1:0]     err_addr,
    output logic              ue_irq
);

    state_t            r_state, w_next;
    logic              r_we;
    logic [3:0]        r_be;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mem_en, r_mem_we;
    logic [AW-1:0]     r_mem_addr;
    logic [CODE_W-1:0] r_mem_wdata;
    logic              r_rsp_valid, r_rsp_corr, r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [15:0]       r_ce_count, r_ue_count;
    logic [AW-1:0]     r_err_addr;
    logic              r_ue_irq;

    logic              w_en, w_we, w_rv, w_corr, w_err, w_cap, w_chk;
    logic [AW-1:0]     w_addr;
    logic [CODE_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata, w_merge, w_enc_in, w_dec_data;
    logic [CODE_W-1:0] w_enc_code;
    logic              w_dec_corr, w_dec_uncorr;
    logic              w_pend;
    logic [AW-1:0]     w_scrub_addr;

    ecc_codec u_codec (
        .i_enc_data   (w_enc_in),
        .o_enc_code   (w_enc_code),
        .i_dec_code   (mem_rdata),
        .o_dec_data   (w_dec_data),
        .o_dec_corr   (w_dec_corr),
        .o_dec_uncorr (w_dec_uncorr)
    );

`ifdef ECC_SCRUB_EN
    localparam int TW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    logic [TW-1:0] r_timer;
    logic          r_scrub_pend;
    logic [AW-1:0] r_scrub_addr;

    // Scrub timer, pending flag and sweep pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer      <= '0;
            r_scrub_pend <= 1'b0;
            r_scrub_addr <= '0;
        end else begin
            if (r_timer == TW'(SCRUB_INTERVAL - 1)) begin
                r_timer      <= '0;
                r_scrub_pend <= 1'b1;
            end else begin
                r_timer <= r_timer + 1'b1;
                if (r_state == IDLE) r_scrub_pend <= 1'b0;
            end
            if (r_state == S_CHK) r_scrub_addr <= r_scrub_addr + 1'b1;
        end
    end

    assign w_pend       = r_scrub_pend;
    assign w_scrub_addr = r_scrub_addr;
`else
    assign w_pend       = 1'b0;
    assign w_scrub_addr = '0;
`endif

    assign req_ready = !rst && (r_state == IDLE) && !w_pend;
    assign w_chk     = (r_state == CHK) || (r_state == S_CHK);

    // Byte merge of captured store data over the corrected old word
    always_comb begin
        w_merge = w_dec_data;
        for (int b = 0; b < 4; b++) begin
            if (r_be[b]) w_merge[8*b +: 8] = r_wdata[8*b +: 8];
        end
    end

    assign w_enc_in = (r_state == CHK)   ? (r_we ? w_merge : w_dec_data) :
                      (r_state == S_CHK) ? w_dec_data : req_wdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and next values of the registered outputs
    always_comb begin
        w_next  = r_state;
        w_en    = 1'b0;
        w_we    = 1'b0;
        w_addr  = r_mem_addr;
        w_wdata = r_mem_wdata;
        w_rv    = 1'b0;
        w_rdata = '0;
        w_corr  = 1'b0;
        w_err   = 1'b0;
        w_cap   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pend) begin
                    w_next = S_RD;
                    w_en   = 1'b1;
                    w_addr = w_scrub_addr;
                end else if (req_valid) begin
                    w_cap  = 1'b1;
                    w_en   = 1'b1;
                    w_addr = req_addr;
                    if (req_we && (req_be == 4'hF)) begin
                        w_next  = WR;
                        w_we    = 1'b1;
                        w_wdata = w_enc_code;
                        w_rv    = 1'b1;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD: w_next = CHK;
            CHK: begin
                w_rv   = 1'b1;
                w_corr = w_dec_corr;
                w_err  = w_dec_uncorr;
                if (!r_we) w_rdata = w_dec_data;
                if (r_we ? !w_dec_uncorr : w_dec_corr) begin
                    w_next  = WB;
                    w_en    = 1'b1;
                    w_we    = 1'b1;
                    w_wdata = w_enc_code;
                end else begin
                    w_next = RESP;
                end
            end
            S_RD: w_next = S_CHK;
            S_CHK: begin
                if (w_dec_corr) begin
                    w_next  = S_WB;
                    w_en    = 1'b1;
                    w_we    = 1'b1;
                    w_wdata = w_enc_code;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Output registers and captured request fields
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_corr  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= 4'h0;
            r_wdata     <= '0;
        end else begin
            r_mem_en    <= w_en;
            r_mem_we    <= w_we;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_rsp_valid <= w_rv;
            r_rsp_rdata <= w_rdata;
            r_rsp_corr  <= w_corr;
            r_rsp_err   <= w_err;
            if (w_cap) begin
                r_we    <= req_we;
                r_be    <= req_be;
                r_wdata <= req_wdata;
            end
        end
    end

    // Saturating error counters, last error address and UE pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ce_count <= '0;
            r_ue_count <= '0;
            r_err_addr <= '0;
            r_ue_irq   <= 1'b0;
        end else begin
            r_ue_irq <= w_chk && w_dec_uncorr;
            if (w_chk && w_dec_corr && (r_ce_count != 16'hFFFF))
                r_ce_count <= r_ce_count + 16'd1;
            if (w_chk && w_dec_uncorr && (r_ue_count != 16'hFFFF))
                r_ue_count <= r_ue_count + 16'd1;
            if (w_chk && (w_dec_corr || w_dec_uncorr))
                r_err_addr <= r_mem_addr;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_corr  = r_rsp_corr;
    assign rsp_err   = r_rsp_err;
    assign ce_count  = r_ce_count;
    assign ue_count  = r_ue_count;
    assign err_addr  = r_err_addr;
    assign ue_irq    = r_ue_irq;

endmodule

// File: doc/ecc_mem_ctrl.md
# ecc_mem_ctrl

SEC-DED protected word memory controller between the core's load/store port and a 39-bit synchronous SRAM. Encodes store data into 39-bit codewords, decodes and corrects load data, performs read-modify-write for sub-word stores, and runs a background scrubber that rewrites single-bit-corrupted words. Maintains error counters and an uncorrectable-error interrupt pulse.

## Interface

- DEPTH, 256: memory depth in 32-bit words (power of 2)
- AW, $clog2(DEPTH): word address width
- SCRUB_INTERVAL, 1024: cycles between scrub operations (≥ 8)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request this cycle
- req_we  in  1  1 = store, 0 = load
- req_be  in  4  byte enables for stores (ignored for loads)
- req_addr  in  AW  word address
- req_wdata  in  32  store data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  corrected load data (0 for stores)
- rsp_corr  out  1  single-bit error corrected
- rsp_err  out  1  uncorrectable error
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  AW  SRAM address
- mem_wdata  out  39  SRAM write codeword
- mem_rdata  in  39  SRAM read codeword, valid one cycle after mem_en with mem_we=0
- ce_count  out  16  corrected-error count, saturating
- ue_count  out  16  uncorrectable-error count, saturating
- err_addr  out  AW  address of most recent error (any type)
- ue_irq  out  1  one-cycle pulse per uncorrectable error

## Operation

- Codeword layout: [31:0] data, [32]=p1, [33]=p2, [34]=p4, [35]=p8, [36]=p16, [37]=p32, [38]=overall parity; Hamming positions 1..38 with data in non-power-of-2 slots in ascending order.
- Decode: syndrome≠0 & overall parity odd → corr; syndrome≠0 & even → uncorr; syndrome=0 & odd → corr (pG-only flip, data intact); syndrome>38 with odd parity → uncorr.
- FSM states: IDLE, WR, RD, CHK, WB, RESP, S_RD, S_CHK, S_WB.
- IDLE: req_ready=1 unless scrub pending. Accept → full store (be=4'hF) to WR; load or partial store to RD.
- WR: write encoded req_wdata; rsp_valid=1; → IDLE.
- RD: mem_en=1, read addr. → CHK.
- CHK: decode mem_rdata. Load: corr → WB (rewrite corrected word), else → RESP. Partial store: uncorr → RESP with rsp_err=1, no write; else merge bytes per be into corrected data → WB.
- WB: write codeword; rsp_valid=1; → IDLE. RESP: rsp_valid=1; → IDLE.
- rsp_rdata on load = corrected data even when uncorr (raw data bits, flagged).
- Scrub: timer counts every cycle; at SCRUB_INTERVAL-1 sets scrub_pend and wraps to 0. IDLE with scrub_pend: scrub wins over req_valid, req_ready=0. S_RD → S_CHK → S_WB only if corr, else IDLE. scrub_addr increments after each scrub, wraps DEPTH-1→0. Scrub never asserts rsp_valid.
- Every corr (request or scrub) increments ce_count, every uncorr increments ue_count and pulses ue_irq; both update err_addr. Counters saturate at 16'hFFFF.
- Captured request fields held in registers from accept until IDLE return.

## Timing

- Reset: req_ready=0, rsp_*=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, counters=0, err_addr=0, ue_irq=0, scrub timer and scrub_addr=0, state IDLE. req_ready=1 from first cycle after reset.
- All outputs registered except req_ready (decoded from state and scrub_pend).
- Handshake at cycle N. Full store: mem write and rsp_valid at N+1. Load/partial store: read at N+1, decode at N+2, rsp_valid (with write-back if any) at N+3.
- Back-to-back: next request accepted earliest in the cycle after rsp_valid.
- ue_irq and counter increments visible the cycle after CHK/S_CHK.
- Scrub latency: 2 cycles clean, 3 with write-back.
- Reset mid-operation aborts without write; in-flight response dropped.

## Configuration

- ECC_SCRUB_EN defined: scrubber, timer, S_* states present.
- Undefined: no scrub logic; req_ready=1 whenever IDLE; memory traffic only from requests.

## Structure

- Package ecc_pkg: DATA_W=32, CODE_W=39, parity bit index constants, FSM state enum typedef, codeword struct typedef.
- Sub-module ecc_codec: combinational encode (32→39) and decode (39→32 + corr/uncorr), instantiated once; one decode path shared by CHK and S_CHK.

## Test plan

- Full store 0xDEADBEEF @5, load @5 → rsp_rdata=0xDEADBEEF, corr=0, err=0, rsp at N+3.
- Flip mem bit 7 @5, load → 0xDEADBEEF, rsp_corr=1, write-back at N+3, ce_count=1, err_addr=5; reload → corr=0.
- Flip bits 3 and 20 @5, load → rsp_err=1, ue_irq pulse, ue_count=1; partial store be=4'h1 @5 → rsp_err=1, no mem write.
- Partial store be=4'h6 data 0x11223344 onto 0xDEADBEEF → read back 0xDE2233EF.
- ECC_SCRUB_EN, SCRUB_INTERVAL=16: flip bit 38 @0, idle 20 cycles → scrub rewrites @0, ce_count=1, scrub_addr=1; req_valid held at scrub start → req_ready=0 until scrub done.
- Force ce_count=16'hFFFF, inject single error → stays 16'hFFFF; assert rst during CHK → no write, all outputs at reset values next cycle.
